// File: rtl/fetch_stage.sv
// fetch_stage: PC generator and IF/ID boundary in front of a synchronous
// instruction memory with a 1-cycle read latency. It tags the returned data
// with its PC, holds the instruction during a decode stall, and drops one
// slot on a branch redirect.
// Optional build macro FETCH_PERF_EN adds fetched/stall/flush counters.
//
// state | meaning
// ------+-------------------------------------------------------------------
// RUN   | id_instr comes straight from imem_rdata (the tagged read)
// HOLD  | decode stalled; id_instr comes from hold_instr, which was captured
//       | on entry because memory has already moved on to pc_q
module fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 1,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_instr,
  output logic              id_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_fetched,
  output logic [CNT_W-1:0]  perf_stalls,
  output logic [CNT_W-1:0]  perf_flushes
`endif
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
  logic              tag_vld_q, tag_vld_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  // State register: sync reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      tag_pc_q  <= '0;
      tag_vld_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tag_pc_q  <= tag_pc_d;
      tag_vld_q <= tag_vld_d;
      hold_q    <= hold_d;
    end
  end

  // Next state: redirect beats stall; a stall only captures data on entry to
  // HOLD, and releasing it advances exactly like a normal RUN cycle.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tag_pc_d  = tag_pc_q;
    tag_vld_d = tag_vld_q;
    hold_d    = hold_q;
    if (branch_taken) begin
      pc_d      = branch_target;
      tag_vld_d = 1'b0;
      state_d   = RUN;
    end else if (stall) begin
      if (state_q == RUN) begin
        hold_d  = imem_rdata;
        state_d = HOLD;
      end
    end else begin
      tag_pc_d  = pc_q;
      tag_vld_d = 1'b1;
      pc_d      = pc_q + ADDR_W'(PC_STEP);
      state_d   = RUN;
    end
  end

  // Outputs: instruction is forced to zero whenever the slot is a bubble.
  always_comb begin
    imem_addr = pc_q;
    id_pc     = tag_pc_q;
    id_valid  = tag_vld_q;
    id_instr  = '0;
    if (tag_vld_q) id_instr = (state_q == HOLD) ? hold_q : imem_rdata;
  end

`ifdef FETCH_PERF_EN
  // Performance counters; free-running, wrap silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
      perf_flushes <= '0;
    end else begin
      if (tag_vld_q && !stall) perf_fetched <= perf_fetched + CNT_W'(1);
      if (stall)               perf_stalls  <= perf_stalls + CNT_W'(1);
      if (branch_taken)        perf_flushes <= perf_flushes + CNT_W'(1);
    end
  end
`endif

endmodule
